// File: rtl/im_fetch_ctrl_pkg.sv
// im_fetch_ctrl_pkg: shared FSM encoding and PC constants for the IM fetch sequencer.
package im_fetch_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/im_fetch_ctrl_if.sv
// im_fetch_ctrl_if: IM read port, decode handshake and control inputs of the fetch sequencer.
// Optional FETCH_PERF_EN adds the perf_fetch/perf_stall counters.
interface im_fetch_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              run;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              im_en;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_rd;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [31:0]       inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_stall;
`endif
    modport master (
        input  run, redirect_valid, redirect_pc, im_rd, inst_ready,
`ifdef FETCH_PERF_EN
        output perf_fetch, perf_stall,
`endif
        output im_en, im_addr, inst_valid, inst, inst_pc
    );
    modport slave (
        output run, redirect_valid, redirect_pc, im_rd, inst_ready,
`ifdef FETCH_PERF_EN
        input  perf_fetch, perf_stall,
`endif
        input  im_en, im_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/im_skid_buf.sv
// im_skid_buf: one-entry holding register for an IM word and its PC; flush wins over push/pop.
module im_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    input  logic [31:0]       pin,
    output logic [DATA_W-1:0] dout,
    output logic [31:0]       pout,
    output logic              full
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
            pout <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            dout <= din;
            pout <= pin;
        end else if (pop) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: PC sequencer feeding decode from a 1-cycle-latency IM, with skid and redirect kill.
// Define FETCH_PERF_EN to add the handshake/stall performance counters.
module im_fetch_ctrl
    import im_fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    im_fetch_ctrl_if.master bus
);
    state_t            state;
    logic [31:0]       pc, req_pc, tgt, issue_pc, skid_pc;
    logic [DATA_W-1:0] skid_inst;
    logic              pending, skid_full, out_load, ret, stall;

    assign tgt      = {bus.redirect_pc[31:2], 2'b00};
    assign issue_pc = bus.redirect_valid ? tgt : pc;
    assign out_load = ~bus.inst_valid | bus.inst_ready;
    assign ret      = pending & ~bus.redirect_valid;
    assign stall    = bus.inst_valid & ~bus.inst_ready;
    // A stalled output with a word already returning leaves no room for another read.
    assign bus.im_en   = ~rst & (bus.redirect_valid ? bus.run
                                 : (state == RUN) & bus.run & ~(stall & pending));
    assign bus.im_addr = issue_pc[ADDR_W+1:2];

    im_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (ret & ~out_load),
        .pop   (out_load & skid_full),
        .flush (bus.redirect_valid),
        .din   (bus.im_rd),
        .pin   (req_pc),
        .dout  (skid_inst),
        .pout  (skid_pc),
        .full  (skid_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            req_pc         <= '0;
            pending        <= 1'b0;
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= '0;
        end else begin
            pending <= bus.im_en;
            if (bus.im_en) req_pc <= issue_pc;
            pc <= bus.im_en ? issue_pc + PC_INC : issue_pc;
            if (bus.redirect_valid) begin
                state          <= bus.run ? RUN : IDLE;
                bus.inst_valid <= 1'b0;
                bus.inst       <= '0;
                bus.inst_pc    <= '0;
            end else begin
                if (out_load) begin
                    bus.inst_valid <= skid_full | ret;
                    bus.inst       <= skid_full ? skid_inst : bus.im_rd;
                    bus.inst_pc    <= skid_full ? skid_pc : req_pc;
                end
                case (state)
                    IDLE:    if (bus.run) state <= RUN;
                    RUN:     if (ret && !out_load) state <= HOLD;
                             else if (!bus.run && !pending) state <= IDLE;
                    HOLD:    if (bus.inst_ready) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.perf_fetch <= '0;
            bus.perf_stall <= '0;
        end else begin
            if (bus.inst_valid && bus.inst_ready) bus.perf_fetch <= bus.perf_fetch + 32'd1;
            if (stall) bus.perf_stall <= bus.perf_stall + 32'd1;
        end
    end
`endif
endmodule
